// File: rtl/seq_det_prog_if.sv
// Serial-stream, configuration and result signals of the programmable sequence detector.
interface seq_det_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);
  logic               ip;
  logic               ip_vld;
  logic               ovl;
  logic               cfg_we;
  logic [LEN_W-1:0]   cfg_len;
  logic [MAX_LEN-1:0] cfg_pat;
  logic               cnt_clr;
  logic               op;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
    output ip, ip_vld, ovl, cfg_we, cfg_len, cfg_pat, cnt_clr,
    input  op, match_cnt, cfg_err
  );

  modport slave (
    input  ip, ip_vld, ovl, cfg_we, cfg_len, cfg_pat, cnt_clr,
    output op, match_cnt, cfg_err
  );
endinterface

// File: rtl/seq_det_prog.sv
// Programmable 1..MAX_LEN bit serial sequence detector with saturating match counter.
// Optional macro SEQ_DET_PROG_REG_OP_EN registers op (one cycle later than the Mealy output).
module seq_det_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'b0000_0110),
  parameter int                 RST_LEN = 5
) (
  input logic          clk,
  input logic          rstn,
  seq_det_prog_if.slave bus
);

  localparam logic [LEN_W:0] ONE_L = (LEN_W + 1)'(1);

  // The oldest history bit never takes part in a compare, so only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0] win;
  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] cand;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic [CNT_W-1:0]   cnt;
  logic               cfg_err_r;
  logic               consume;
  logic               len_ok;
  logic               enough;
  logic               hit;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_fill(input logic [LEN_W-1:0] v);
    return (v >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : v + LEN_W'(1);
  endfunction

  assign consume = bus.ip_vld && !bus.cfg_we;
  assign cand    = {win, bus.ip};
  assign len_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  assign enough  = ({1'b0, fill} + ONE_L) >= {1'b0, len};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign hit = consume && enough && (((cand ^ pat) & mask) == '0);

  // State update: history, fill level, active configuration, counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win       <= '0;
      fill      <= '0;
      pat       <= RST_PAT;
      len       <= LEN_W'(RST_LEN);
      cnt       <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= bus.cfg_we && !len_ok;
      if (bus.cfg_we) begin
        fill <= '0;
        if (len_ok) begin
          pat <= bus.cfg_pat;
          len <= bus.cfg_len;
        end
      end else if (bus.ip_vld) begin
        win  <= cand[MAX_LEN-2:0];
        fill <= (hit && !bus.ovl) ? '0 : sat_inc_fill(fill);
      end
      if (bus.cnt_clr) begin
        cnt <= '0;
      end else if (hit) begin
        cnt <= sat_inc_cnt(cnt);
      end
    end
  end

  assign bus.match_cnt = cnt;
  assign bus.cfg_err   = cfg_err_r;

`ifdef SEQ_DET_PROG_REG_OP_EN
  logic op_r;

  // Output stage: op delayed one cycle behind the final pattern bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_r <= 1'b0;
    end else begin
      op_r <= hit;
    end
  end

  assign bus.op = op_r;
`else
  assign bus.op = hit;
`endif

endmodule
